mux_rr_stream: RTL
==================

Name: mux_rr_stream

Overview:
- Parametrised N:1 stream multiplexer; successor to the combinational 4:1 mux.
- Selects one of N_CH input channels, each with valid/ready handshake, into a single registered output stream.
- Two selection modes:
  - round-robin arbitration among valid channels;
  - fixed select via sel, which preserves the legacy mux behaviour.
- Sits between multiple producers and one consumer in the datapath.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DW, 8, data width per channel in bits.
- SELW, $clog2(N_CH), width of sel and out_ch (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = round-robin, 1 = fixed select.
- sel  in  SELW  channel index used when mode=1.
- in_data  in  N_CH*DW  channel k occupies bits [k*DW +: DW].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready (one-hot or zero).
- out_data  out  DW  registered output data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_ch  out  SELW  source channel index of the current output beat.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0, in_ready=0 during reset.
- Load condition: load = !out_valid || out_ready. The output register accepts a new beat in the same cycle the old one drains, so full throughput is 1 beat/cycle.
- Grant, round-robin (mode=0):
  - Search in_valid starting at rr_ptr, ascending with wrap from N_CH-1 to 0.
  - The first valid channel wins.
  - No valid channel means no grant.
- Grant, fixed select (mode=1):
  - grant = sel if in_valid[sel], else no grant.
  - sel >= N_CH (non-power-of-2 N_CH) means no grant.
- in_ready[g] = load && grant==g; every other bit is 0. in_ready is combinational from in_valid, mode, sel, out_valid, out_ready, rr_ptr.
- Transfer on channel g (in_valid[g] && in_ready[g]) at a clk edge:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod N_CH. rr_ptr updates in both modes, so switching to round-robin continues fairly.
- Output drains with no new grant while load=1: out_valid <= 0; out_data and out_ch keep their last values.
- Stability: while out_valid=1 && out_ready=0, out_data, out_ch and out_valid stay unchanged regardless of input, mode or sel changes.
- Latency: input handshake to out_valid is 1 cycle. No combinational path from in_data to out_data.
- Simultaneous drain and load: handled in one edge; out_valid stays 1 with the new beat.
- Reset mid-operation: any pending output beat is discarded, with no handshake completed on that cycle.
- Producers must hold data stable while valid and not ready. The block does not check this.

Optional Feature:
- Macro: MUX_RR_STREAM_STATS_EN.
- Defined:
  - Adds output port xfer_cnt, width 16: count of completed output transfers (out_valid && out_ready).
  - Saturates at 16'hFFFF.
  - Cleared by rst.
  - Also adds output port stall, width 1: registered, set for one cycle after any cycle with out_valid && !out_ready.
- Undefined: neither port exists and there is no counter logic. Core behaviour is identical in both builds.

Decomposition:
- Package mux_rr_pkg holds:
  - MODE_RR=1'b0, MODE_FIXED=1'b1;
  - the maximum supported channel count constant, 16;
  - the stats counter width constant, 16.
- Sub-module rr_arbiter (params N_CH):
  - inputs req[N_CH], ptr[SELW];
  - outputs gnt_vld and gnt_idx[SELW];
  - purely combinational priority rotate.
- mux_rr_stream instantiates rr_arbiter and adds the fixed-select override, output register, pointer register and optional stats.

Test Plan:
- Reset → out_valid=0, out_data=0, out_ch=0, in_ready=0. Then mode=0, all in_valid=0 → out_valid stays 0.
- Legacy check: mode=1, sel=2, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=4'b1111, out_ready=1 → next cycle out_data=8'h33, out_ch=2; in_ready=4'b0100 every cycle.
- Round-robin: mode=0, all four valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,… one beat per cycle.
- Round-robin with gaps: mode=0, in_valid=4'b1010 → out_ch alternates 1,3,1,3. Drop in_valid[3] → only 1.
- Backpressure: out_valid=1 with out_data=8'h22, hold out_ready=0 for 5 cycles while changing inputs and sel → out_data stays 8'h22 and in_ready=0. Raise out_ready → next beat loads in the same cycle.
- Stats build (MUX_RR_STREAM_STATS_EN): 10 transfers plus 3 stall cycles → xfer_cnt=10, stall pulses seen 3 times. Assert rst mid-stream → xfer_cnt=0 and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/mux_rr_pkg.sv
// Shared constants for the N:1 round-robin stream multiplexer.
// The optional statistics build is enabled with MUX_RR_STREAM_STATS_EN.
package mux_rr_pkg;

  // Selection mode encodings carried on the mode input
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Largest channel count the multiplexer is sized for
  localparam int MAX_CH = 16;

  // Width of the saturating transfer counter in the statistics build
  localparam int STATS_W = 16;

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// Combinational rotating-priority arbiter. The search starts at ptr and
// walks upward with wrap-around; the first requesting channel wins.
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  // Walk priority offsets from lowest to highest precedence so that the
  // closest requester to ptr is the last (and winning) assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      for (int k = 0; k < N_CH; k++) begin
        if (req[k] && (k == ((int'(ptr) + i) % N_CH))) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N:1 stream multiplexer with a registered output stage. Channels are
// chosen either by round-robin arbitration (mode=0) or by the legacy fixed
// select (mode=1). The output register refills in the same cycle it drains,
// giving one beat per cycle at full throughput.
// Defining MUX_RR_STREAM_STATS_EN adds the xfer_cnt and stall status ports.
module mux_rr_stream
  import mux_rr_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_valid,
  output logic [N_CH-1:0]    in_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
`ifdef MUX_RR_STREAM_STATS_EN
  ,
  output logic [STATS_W-1:0] xfer_cnt,
  output logic               stall
`endif
);

  // Pointer after a grant to g: the channel just above g, wrapping at N_CH.
  function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] g);
    if (g == SELW'(N_CH - 1)) begin
      return '0;
    end
    return g + SELW'(1);
  endfunction

  logic [SELW-1:0] rr_ptr;

  logic            load_p0;
  logic            arb_vld_p0;
  logic [SELW-1:0] arb_idx_p0;
  logic            fix_vld_p0;
  logic [SELW-1:0] fix_idx_p0;
  logic            gnt_vld_p0;
  logic [SELW-1:0] gnt_idx_p0;
  logic            xfer_p0;
  logic [DW-1:0]   gnt_data_p0;

  // ---- stage p0: grant selection and input handshake (combinational) ----

  rr_arbiter #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_vld (arb_vld_p0),
    .gnt_idx (arb_idx_p0)
  );

  // Fixed select: grant only when sel names an existing, valid channel.
  // Comparing against each constant index keeps out-of-range sel harmless.
  always_comb begin
    fix_vld_p0 = 1'b0;
    fix_idx_p0 = sel;
    for (int k = 0; k < N_CH; k++) begin
      if ((sel == SELW'(k)) && in_valid[k]) begin
        fix_vld_p0 = 1'b1;
      end
    end
  end

  // Mode mux between the arbiter result and the fixed-select override.
  always_comb begin
    if (mode == MODE_FIXED) begin
      gnt_vld_p0 = fix_vld_p0;
      gnt_idx_p0 = fix_idx_p0;
    end else begin
      gnt_vld_p0 = arb_vld_p0;
      gnt_idx_p0 = arb_idx_p0;
    end
  end

  // The output register can take a beat when empty or when it drains now;
  // reset blocks any handshake so no beat is accepted during rst.
  always_comb begin
    load_p0 = !out_valid || out_ready;
    xfer_p0 = !rst && load_p0 && gnt_vld_p0;
  end

  // One-hot ready towards the granted channel and matching data select.
  always_comb begin
    in_ready    = '0;
    gnt_data_p0 = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx_p0 == SELW'(k)) begin
        in_ready[k] = xfer_p0;
        gnt_data_p0 = in_data[k*DW +: DW];
      end
    end
  end

  // ---- stage p1: output register and round-robin pointer ----

  // Load a granted beat, or empty the register when it drains with no grant;
  // while the consumer stalls, everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_p0) begin
      out_valid <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        out_data <= gnt_data_p0;
        out_ch   <= gnt_idx_p0;
        rr_ptr   <= next_ptr(gnt_idx_p0);
      end
    end
  end

`ifdef MUX_RR_STREAM_STATS_EN
  // Saturating count of completed output transfers and a one-cycle stall
  // flag registered from every cycle the consumer holds off a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      if (out_valid && out_ready && (xfer_cnt != {STATS_W{1'b1}})) begin
        xfer_cnt <= xfer_cnt + STATS_W'(1);
      end
      stall <= out_valid && !out_ready;
    end
  end
`endif

endmodule
